regfile_dump: RTL and testbench
===============================

Name: regfile_dump

Overview:
- Debug/trace reader for the CPU register file.
- On a start pulse it walks the register file's read port from low to high index.
- Each register is captured and emitted as an {index, data} record on a valid/ready stream toward the debug/trace sink.
- Sits beside decode and shares a read port (address out, combinational data in) through a debug mux.

Parameters:
- NUM_REGS, 32, number of architectural registers dumped.
- ADDR_W, 5, register index width; NUM_REGS <= 2**ADDR_W.
- DATA_W, 32, register data width.
- SKIP_ZERO, 0, when 1 the dump starts at index 1; register 0 is never emitted.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  in  1  cancels a dump in progress.
- rd_addr  out  ADDR_W  register index driven to the regfile read port.
- rd_data  in  DATA_W  combinational read data for rd_addr; index 0 reads 0.
- out_valid  out  1  record available.
- out_ready  in  1  sink accepts the record.
- out_idx  out  ADDR_W  register index of the record.
- out_data  out  DATA_W  register value of the record.
- busy  out  1  high in LOAD and SEND.
- done  out  1  one-cycle pulse after the last record is accepted.

Behaviour:
- Reset (async assert, sync release): state=IDLE, idx=0, rd_addr=0, out_valid=0, out_idx=0, out_data=0, busy=0, done=0.
- rd_addr = idx continuously.
- busy is decoded from state (LOAD or SEND).
- FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE: if start=1, idx <= (SKIP_ZERO ? 1 : 0) and go to LOAD. Otherwise hold.
  - LOAD (one cycle): out_data <= rd_data, out_idx <= idx, out_valid <= 1, go to SEND.
  - SEND:
    - out_valid, out_idx and out_data stay stable until out_valid && out_ready.
    - On handshake: out_valid <= 0.
    - If idx == NUM_REGS-1, go to DONE. Otherwise idx <= idx+1 and go to LOAD.
  - DONE: done=1 for exactly this cycle, then go to IDLE. idx is left at NUM_REGS-1.
- Throughput: 2 cycles per register minimum when out_ready=1. Each cycle of out_ready=0 in SEND adds one cycle.
- Snapshot semantics:
  - The value emitted is rd_data as sampled in that register's LOAD cycle.
  - A regfile write landing on the same clock edge is not reflected; the pre-write value is emitted.
  - Later writes to an already-captured register are not reflected.
- start while busy or in DONE: ignored, no restart, no queuing.
- abort:
  - In LOAD or SEND: next state IDLE and out_valid <= 0. This is the only case where out_valid drops without a handshake.
  - No done pulse is produced.
  - abort wins over a simultaneous handshake.
  - abort in IDLE or DONE has no effect; a DONE pulse still completes.
- abort and start together in IDLE: start wins; abort is ignored in IDLE.
- Index arithmetic: ADDR_W bits with no wrap past NUM_REGS-1. The terminal compare uses NUM_REGS-1.
- rst_n asserted mid-dump: all outputs return to reset values immediately (asynchronously). No partial done.

Test Plan:
- Preload regs with reg[i] = 0x100+i and reg[29] = 1000. Pulse start at cycle 0 with out_ready=1.
  - Required: records idx 0..31 in order; idx 0 data = 0; idx 29 data = 1000.
  - First out_valid at cycle 2, last record at cycle 64, done=1 only at cycle 65, busy high for cycles 1–64.
- Stall: random out_ready (about 50%).
  - Required: out_idx and out_data never change while out_valid=1 && out_ready=0.
  - Same 32 records as the first test; done only after idx 31 is accepted.
- SKIP_ZERO=1:
  - Required: first record idx=1, 31 records total, done after idx 31.
- Write collision: regwrite to reg 5 (value 0xDEAD) on the same edge as idx 5's LOAD capture.
  - Required: emitted data is the old value 0x105.
  - A second dump emits 0xDEAD.
- Abort during SEND of idx 10 with out_ready=1 in the same cycle.
  - Required: out_valid=0 and state IDLE the next cycle, no done.
  - A new start restarts from idx 0.
- start pulses during busy are ignored.
- rst_n low mid-dump: immediately out_valid=0, busy=0, rd_addr=0.

Source files
------------

// File: rtl/regfile_dump.sv
// Debug/trace reader: walks the register file read port from low to high index and
// emits each captured register as an {index, data} record on a valid/ready stream.
module regfile_dump #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter bit          SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FirstIdx = SKIP_ZERO ? ADDR_W'(1) : '0;

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                out_valid_q;
  logic [ADDR_W-1:0]   out_idx_q;
  logic [DATA_W-1:0]   out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // abort is meaningless here; start alone decides
          if (start) begin
            idx_q   <= FirstIdx;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (abort) begin
            state_q <= StIdle;
          end else begin
            out_data_q  <= rd_data;
            out_idx_q   <= idx_q;
            out_valid_q <= 1'b1;
            state_q     <= StSend;
          end
        end
        StSend: begin
          // abort takes priority over a handshake in the same cycle
          if (abort) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == LastIdx) begin
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= StLoad;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd_addr   = idx_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == StLoad) || (state_q == StSend);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: two instances (SKIP_ZERO off/on) share a modelled register file.
module tb_regfile_dump;

  logic        clk;
  logic        rst_n;
  logic        start1, start2, abort, out_ready, sel;
  logic [4:0]  rd_addr1, rd_addr2, idx1, idx2;
  logic [31:0] rd_data1, rd_data2, data1, data2;
  logic        v1, v2, busy1, busy2, done1, done2;
  logic [31:0] regs [32];
  logic        dead5;

  int n_checks = 0;
  int n_fail   = 0;

  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];

  logic        m_valid, m_busy, m_done;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  assign m_valid = sel ? v2 : v1;
  assign m_busy  = sel ? busy2 : busy1;
  assign m_done  = sel ? done2 : done1;
  assign m_idx   = sel ? idx2 : idx1;
  assign m_data  = sel ? data2 : data1;

  regfile_dump u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .out_valid(v1), .out_ready(out_ready),
    .out_idx(idx1), .out_data(data1), .busy(busy1), .done(done1)
  );

  regfile_dump #(.SKIP_ZERO(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .out_valid(v2), .out_ready(out_ready),
    .out_idx(idx2), .out_data(data2), .busy(busy2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish before 500us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_val(input int i);
    if (i == 0) return 32'h0;
    if (i == 29) return 32'd1000;
    if (i == 5 && dead5) return 32'hDEAD;
    return 32'h100 + i;
  endfunction

  // One full dump on the selected instance; timed=1 also checks exact cycle positions
  // (requires out_ready=1 throughout), poke=1 pulses start while busy and in DONE.
  task automatic run_dump(input bit s, input bit stall, input bit timed, input bit poke,
                          input int exp_first, output int nrec, output int first,
                          output int last, output int ndone);
    int c;
    int nxt;
    bit hold;
    bit fin;
    logic [4:0]  p_idx;
    logic [31:0] p_data;
    nrec = 0; first = -1; last = -1; ndone = 0;
    hold = 1'b0; fin = 1'b0; nxt = exp_first; p_idx = '0; p_data = '0;
    sel = s;
    @(negedge clk);
    out_ready = 1'b1;
    if (s) start2 = 1'b1; else start1 = 1'b1;
    c = 0;
    while (!fin && c < 400) begin
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      c++;
      if (hold) begin
        check("stall_idx", m_idx, p_idx);
        check("stall_data", m_data, p_data);
      end
      if (timed) begin
        check("cyc_valid", m_valid, (c >= 2 && c <= 64 && c % 2 == 0));
        check("cyc_busy", m_busy, (c >= 1 && c <= 64));
        check("cyc_done", m_done, (c == 65));
      end
      if (m_done) begin
        ndone++;
        fin = 1'b1;
      end
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && (c % 5 == 0 || m_done)) begin
        if (s) start2 = 1'b1; else start1 = 1'b1;
      end
      if (m_valid && out_ready) begin
        check("rec_idx", m_idx, nxt);
        check("rec_data", m_data, exp_val(nxt));
        if (nrec == 0) first = m_idx;
        last = m_idx;
        nrec++;
        nxt++;
      end
      hold = m_valid && !out_ready;
      p_idx = m_idx;
      p_data = m_data;
    end
    if (!fin) check("done_timeout", 0, 1);
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    check("idle_after_done", {m_busy, m_valid, m_done}, 3'b000);
    out_ready = 1'b1;
  endtask

  typedef struct {
    bit s;
    bit stall;
    bit timed;
    bit poke;
    int exp_first;
    int exp_n;
    int exp_last;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int nrec, first, last, ndone;
    bit found;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 32, 31};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 32, 31};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 31, 31};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 31, 31};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 32, 31};

    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
    regs[0] = 32'h0;
    regs[29] = 32'd1000;
    dead5 = 1'b0;
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; abort = 1'b0; out_ready = 1'b1; sel = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_valid", {v1, v2}, 2'b00);
    check("rst_busy", {busy1, busy2}, 2'b00);
    check("rst_done", {done1, done2}, 2'b00);
    check("rst_rd_addr", {rd_addr1, rd_addr2}, 10'h0);
    check("rst_out_idx", {idx1, idx2}, 10'h0);
    check("rst_out_data", {data1, data2}, 64'h0);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_dump(vecs[v].s, vecs[v].stall, vecs[v].timed, vecs[v].poke, vecs[v].exp_first,
               nrec, first, last, ndone);
      check("vec_first", first, vecs[v].exp_first);
      check("vec_count", nrec, vecs[v].exp_n);
      check("vec_last", last, vecs[v].exp_last);
      check("vec_done", ndone, 1);
    end

    // Write to reg 5 on the edge that captures it: old value must be emitted
    fork
      run_dump(1'b0, 1'b0, 1'b0, 1'b0, 0, nrec, first, last, ndone);
      begin
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (busy1 && !v1 && rd_addr1 == 5'd5) begin
            found = 1'b1;
            break;
          end
        end
        if (found) begin
          @(posedge clk);
          regs[5] <= 32'hDEAD;
        end
        check("coll_reach_load5", found, 1);
      end
    join
    check("coll_count", nrec, 32);
    dead5 = 1'b1;
    run_dump(1'b0, 1'b0, 1'b0, 1'b0, 0, nrec, first, last, ndone);
    check("coll_second_count", nrec, 32);

    // Abort during SEND of idx 10 together with a handshake
    sel = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (v1 && idx1 == 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reach_idx10", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", v1, 0);
    check("abort_busy", busy1, 0);
    check("abort_done", done1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_quiet", {busy1, v1, done1}, 3'b000);
    end
    run_dump(1'b0, 1'b0, 1'b1, 1'b0, 0, nrec, first, last, ndone);
    check("abort_restart_first", first, 0);
    check("abort_restart_count", nrec, 32);

    // Asynchronous reset in the middle of a dump
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (8) @(negedge clk);
    check("rstmid_pre_busy", busy1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_valid", v1, 0);
    check("rstmid_busy", busy1, 0);
    check("rstmid_rd_addr", rd_addr1, 0);
    check("rstmid_done", done1, 0);
    check("rstmid_out", {idx1, data1}, 37'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_idle", {busy1, v1, done1}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
